// File: rtl/cdc_pkg.sv
// Shared defaults for the CDC receive path and a helper for the FIFO level/pointer width.
package cdc_pkg;

    localparam int unsigned DefBusWidth  = 8;
    localparam int unsigned DefDepthLog2 = 2;

    // Pointers and the level count carry one extra bit so that full and empty are distinguishable.
    function automatic int unsigned level_width(int unsigned depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/bus_rx_buffer_if.sv
// Stream bundle around bus_rx_buffer: synchronizer pulse input, valid/ready output, status flags.
// Optional status signals exist only when BUS_RX_BUFFER_STATUS_EN is defined.
interface bus_rx_buffer_if
    import cdc_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DefBusWidth,
    parameter int unsigned DEPTH_LOG2 = DefDepthLog2
);

    logic                 s_tvalid;
    logic [BUS_WIDTH-1:0] s_tdata;
    logic                 m_tvalid;
    logic                 m_tready;
    logic [BUS_WIDTH-1:0] m_tdata;
    logic                 full;
    logic                 empty;
    logic                 overflow;
`ifdef BUS_RX_BUFFER_STATUS_EN
    logic                                    ovf_sticky;
    logic                                    ovf_clr;
    logic [level_width(DEPTH_LOG2)-1:0]      level;

    modport slave (
        input  s_tvalid, s_tdata, m_tready, ovf_clr,
        output m_tvalid, m_tdata, full, empty, overflow, ovf_sticky, level
    );
    modport master (
        output s_tvalid, s_tdata, m_tready, ovf_clr,
        input  m_tvalid, m_tdata, full, empty, overflow, ovf_sticky, level
    );
`else
    modport slave (
        input  s_tvalid, s_tdata, m_tready,
        output m_tvalid, m_tdata, full, empty, overflow
    );
    modport master (
        output s_tvalid, s_tdata, m_tready,
        input  m_tvalid, m_tdata, full, empty, overflow
    );
`endif

endinterface

// File: rtl/bus_rx_fifo_mem.sv
// Storage array for bus_rx_buffer: synchronous write, asynchronous read, no reset on the contents.
module bus_rx_fifo_mem #(
    parameter int unsigned Width = 8,
    parameter int unsigned AddrW = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AddrW-1:0] waddr_i,
    input  logic [Width-1:0] wdata_i,
    input  logic [AddrW-1:0] raddr_i,
    output logic [Width-1:0] rdata_o
);

    logic [Width-1:0] mem_q [2**AddrW];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_rx_buffer.sv
// Elastic buffer behind the data bus synchronizer: captures pulsed words, re-presents them as a
// valid/ready stream, flags overflow. BUS_RX_BUFFER_STATUS_EN adds ovf_sticky/ovf_clr/level.
module bus_rx_buffer
    import cdc_pkg::*;
#(
    parameter int unsigned BUS_WIDTH  = DefBusWidth,
    parameter int unsigned DEPTH_LOG2 = DefDepthLog2
) (
    input logic            aclk_o,
    input logic            arstn_o,
    bus_rx_buffer_if.slave bus
);

    localparam int unsigned PtrW = level_width(DEPTH_LOG2);

    logic                 wr_pend_q;
    logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
    logic                 empty, full, do_wr, do_rd;
    logic [BUS_WIDTH-1:0] rdata;

    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                   (wr_ptr_q[PtrW-2:0] == rd_ptr_q[PtrW-2:0]);
        do_rd    = !empty && bus.m_tready;
        // A read in the same cycle frees the slot, so a write while full still lands.
        do_wr    = wr_pend_q && (!full || do_rd);
        wr_ptr_d = wr_ptr_q + PtrW'(do_wr);
        rd_ptr_d = rd_ptr_q + PtrW'(do_rd);
    end

    // Data trails the pulse by one cycle, so the pulse is delayed to line up with it.
    always_ff @(posedge aclk_o or negedge arstn_o) begin
        if (!arstn_o) begin
            wr_pend_q <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            wr_pend_q <= bus.s_tvalid;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    bus_rx_fifo_mem #(
        .Width (BUS_WIDTH),
        .AddrW (DEPTH_LOG2)
    ) u_mem (
        .clk_i   (aclk_o),
        .we_i    (do_wr),
        .waddr_i (wr_ptr_q[PtrW-2:0]),
        .wdata_i (bus.s_tdata),
        .raddr_i (rd_ptr_q[PtrW-2:0]),
        .rdata_o (rdata)
    );

    // Unreset array contents are masked while empty so the output reads zero out of reset.
    assign bus.m_tvalid = !empty;
    assign bus.m_tdata  = empty ? '0 : rdata;
    assign bus.full     = full;
    assign bus.empty    = empty;
    assign bus.overflow = wr_pend_q && full && !do_rd;

`ifdef BUS_RX_BUFFER_STATUS_EN
    logic            ovf_sticky_q;
    logic [PtrW-1:0] level_q;

    always_ff @(posedge aclk_o or negedge arstn_o) begin
        if (!arstn_o) begin
            ovf_sticky_q <= 1'b0;
            level_q      <= '0;
        end else begin
            level_q <= wr_ptr_d - rd_ptr_d;
            if (bus.overflow) begin
                ovf_sticky_q <= 1'b1;
            end else if (bus.ovf_clr) begin
                ovf_sticky_q <= 1'b0;
            end
        end
    end

    assign bus.ovf_sticky = ovf_sticky_q;
    assign bus.level      = level_q;
`endif

endmodule

// File: tb/tb_bus_rx_buffer.sv
// Directed scoreboard bench for bus_rx_buffer: expected words queued on drive, popped on transfer.
module tb_bus_rx_buffer;

    logic aclk_o  = 1'b0;
    logic arstn_o = 1'b0;

    bus_rx_buffer_if #(.BUS_WIDTH(8), .DEPTH_LOG2(2)) bus ();

    bus_rx_buffer #(
        .BUS_WIDTH  (8),
        .DEPTH_LOG2 (2)
    ) dut (
        .aclk_o  (aclk_o),
        .arstn_o (arstn_o),
        .bus     (bus)
    );

    always #5 aclk_o = ~aclk_o;

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [7:0]  exp_q[$];
    int unsigned ovf_cnt = 0;
    logic        watch_full = 1'b0;
    logic        full_seen = 1'b0;
    logic        prev_hold = 1'b0;
    logic [7:0]  prev_data = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called with inputs already driven for this cycle; samples, then advances one clock.
    task automatic tick();
        #2;
        if (bus.overflow === 1'b1) ovf_cnt++;
        if (watch_full && bus.full !== 1'b0) full_seen = 1'b1;
        if (prev_hold && bus.m_tvalid === 1'b1) check("hold_stable", bus.m_tdata, prev_data);
        if (bus.m_tvalid === 1'b1 && bus.m_tready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", {24'h0, bus.m_tdata}, 32'hFFFF_FFFF);
            end else begin
                check("rd_data", {24'h0, bus.m_tdata}, {24'h0, exp_q.pop_front()});
            end
        end
        prev_hold = (bus.m_tvalid === 1'b1) && (bus.m_tready === 1'b0);
        prev_data = bus.m_tdata;
        @(posedge aclk_o);
        #1;
    endtask

    task automatic pulse(input logic [7:0] data);
        bus.s_tvalid = 1'b1;
        exp_q.push_back(data);
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = data;
        tick();
    endtask

    task automatic drain(input int n);
        bus.m_tready = 1'b1;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = '0;
        bus.m_tready = 1'b0;
`ifdef BUS_RX_BUFFER_STATUS_EN
        bus.ovf_clr  = 1'b0;
`endif
        // 1. Reset state
        repeat (3) @(posedge aclk_o);
        #1;
        check("rst_m_tvalid", bus.m_tvalid, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_overflow", bus.overflow, 0);
        check("rst_m_tdata", bus.m_tdata, 0);
        arstn_o = 1'b1;
        @(posedge aclk_o);
        #1;

        // 2. Single word, two-cycle latency
        bus.m_tready = 1'b1;
        bus.s_tvalid = 1'b1;
        exp_q.push_back(8'hA5);
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'hA5;
        #2;
        check("lat_n1_m_tvalid", bus.m_tvalid, 0);
        tick();
        #2;
        check("lat_n2_m_tvalid", bus.m_tvalid, 1);
        check("lat_n2_m_tdata", bus.m_tdata, 8'hA5);
        tick();
        check("single_empty", bus.empty, 1);

        // 3. Fill with back-to-back pulses, then drain in order
        bus.m_tready = 1'b0;
        for (int i = 0; i <= 4; i++) begin
            bus.s_tvalid = (i < 4);
            bus.s_tdata  = 8'(i);
            if (i < 4) exp_q.push_back(8'(i + 1));
            tick();
        end
        check("fill_full", bus.full, 1);
        check("fill_no_ovf", ovf_cnt, 0);
        drain(4);
        check("fill_drain_empty", bus.empty, 1);
        check("fill_queue_empty", exp_q.size(), 0);

        // 4a. Overflow while full and stalled: 8'h55 must be dropped
        bus.m_tready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(8'(8'h11 + i));
        bus.s_tvalid = 1'b1;
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h55;
        #2;
        check("ovf_pulse", bus.overflow, 1);
        tick();
        check("ovf_one_cycle", bus.overflow, 0);
        check("ovf_still_full", bus.full, 1);
        drain(5);
        check("ovf_drain_empty", bus.empty, 1);
        check("ovf_queue_empty", exp_q.size(), 0);

        // 4b. Write while full with a simultaneous read: no drop, level unchanged
        ovf_cnt = 0;
        bus.m_tready = 1'b0;
        for (int i = 0; i < 4; i++) pulse(8'(8'h21 + i));
        bus.s_tvalid = 1'b1;
        exp_q.push_back(8'h55);
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h55;
        bus.m_tready = 1'b1;
        #2;
        check("rw_full_no_ovf", bus.overflow, 0);
        tick();
        check("rw_full_level", bus.full, 1);
        drain(5);
        check("rw_drain_empty", bus.empty, 1);
        check("rw_queue_empty", exp_q.size(), 0);
        check("rw_ovf_cnt", ovf_cnt, 0);

        // 5. Twenty words with toggling ready: pointers wrap, nothing lost, never full
        ovf_cnt    = 0;
        watch_full = 1'b1;
        bus.m_tready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            bus.s_tvalid = 1'b1;
            bus.m_tready = ~bus.m_tready;
            exp_q.push_back(8'(8'h40 + i));
            tick();
            bus.s_tvalid = 1'b0;
            bus.s_tdata  = 8'(8'h40 + i);
            bus.m_tready = ~bus.m_tready;
            tick();
        end
        drain(4);
        watch_full = 1'b0;
        check("wrap_queue_empty", exp_q.size(), 0);
        check("wrap_never_full", full_seen, 0);
        check("wrap_no_ovf", ovf_cnt, 0);
        check("wrap_empty", bus.empty, 1);

        // 6. Reset mid-stream, with a write still pending
        bus.m_tready = 1'b0;
        for (int i = 0; i < 3; i++) pulse(8'(8'h71 + i));
        bus.s_tvalid = 1'b1;
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tdata  = 8'h99;
        arstn_o = 1'b0;
        exp_q.delete();
        prev_hold = 1'b0;
        #2;
        check("midrst_empty", bus.empty, 1);
        check("midrst_m_tvalid", bus.m_tvalid, 0);
        @(posedge aclk_o);
        #1;
        arstn_o = 1'b1;
        @(posedge aclk_o);
        #1;
        check("postrst_empty", bus.empty, 1);
        pulse(8'h3C);
        bus.m_tready = 1'b1;
        #2;
        check("postrst_first", bus.m_tdata, 8'h3C);
        drain(3);
        check("postrst_queue_empty", exp_q.size(), 0);
        check("postrst_drained", bus.empty, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
